// File: rtl/exception_redirect_ctrl_pkg.sv
// Shared definitions for the exception redirect controller: exception
// codes, FSM state encoding and the default exception vector.
package exception_redirect_ctrl_pkg;

    // Exception codes written to cause[6:2]
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [4:0] EXC_SYS = 5'd8;

    // Default exception vector driven on an exception redirect
    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0180;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

endpackage

// File: rtl/exception_redirect_ctrl_exc_priority_enc.sv
// Combinational priority encoder: turns the Writeback exception flags into
// an exception code. RI beats OV beats SYS; valid is high when any flag is set.
module exc_priority_enc
    import exception_redirect_ctrl_pkg::*;
(
    input  logic       ri,
    input  logic       ov,
    input  logic       sys,
    output logic [4:0] code,
    output logic       valid
);

    // Highest-priority flag selects the code
    always_comb begin
        valid = ri | ov | sys;
        code  = 5'd0;
        if (ri) begin
            code = EXC_RI;
        end else if (ov) begin
            code = EXC_OV;
        end else if (sys) begin
            code = EXC_SYS;
        end
    end

endmodule

// File: rtl/exception_redirect_ctrl.sv
// Exception / ERET redirect controller at the Writeback stage.
// An exception saves the PC into epc, records the code in cause and redirects
// Fetch to HANDLER_ADDR with a one-cycle flush of F/D/E/M; ERET from the
// handler redirects back to epc. The redirect appears in the cycle right
// after the triggering Writeback cycle.
// Optional feature macro: EXC_STATUS_EN -- when defined, an exception taken
// while already in the handler is not serviced; it only sets the sticky
// lost-exception flag cause[31]. When undefined it is serviced like one
// taken from IDLE and cause[31] stays 0.
// Handshake note: valid_w qualifies every Writeback flag; there is no back
// pressure, an event is consumed in the cycle it is presented or dropped.
module exception_redirect_ctrl
    import exception_redirect_ctrl_pkg::*;
#(
    parameter int                    WIDTH_32     = 32,
    parameter logic [WIDTH_32-1:0]   HANDLER_ADDR = WIDTH_32'(HANDLER_ADDR_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_w,
    input  logic [WIDTH_32-1:0] pc_w,
    input  logic                exc_ri_w,
    input  logic                exc_ov_w,
    input  logic                exc_sys_w,
    input  logic                eret_w,
    output logic [WIDTH_32-1:0] redir_pc,
    output logic                redir_en,
    output logic                flush_f,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_m,
    output logic [WIDTH_32-1:0] epc,
    output logic [WIDTH_32-1:0] cause,
    output logic                in_handler,
    output logic [1:0]          state_dbg
);

    state_t              state_q, state_d;
    logic [WIDTH_32-1:0] epc_q, epc_d;
    logic [WIDTH_32-1:0] tgt_q, tgt_d;
    logic [4:0]          code_q, code_d;
    logic                lost_q, lost_d;
    logic                tgt_exc_q, tgt_exc_d;

    logic [4:0]          enc_code;
    logic                enc_valid;
    logic                exc_evt;
    logic                ret_evt;

    exc_priority_enc u_enc (
        .ri    (exc_ri_w),
        .ov    (exc_ov_w),
        .sys   (exc_sys_w),
        .code  (enc_code),
        .valid (enc_valid)
    );

    // An exception flag beats a simultaneous ERET; nothing counts without valid_w
    assign exc_evt = valid_w & enc_valid;
    assign ret_evt = valid_w & eret_w & ~enc_valid;

    // Next-state and register-update logic
    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        tgt_d     = tgt_q;
        code_d    = code_q;
        lost_d    = lost_q;
        tgt_exc_d = tgt_exc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_evt) begin
                    epc_d     = pc_w;
                    code_d    = enc_code;
                    tgt_d     = HANDLER_ADDR;
                    tgt_exc_d = 1'b1;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Instructions seen here are being flushed, so events are dropped
                state_d = tgt_exc_q ? ST_HANDLER : ST_IDLE;
            end
            ST_HANDLER: begin
                if (exc_evt) begin
`ifdef EXC_STATUS_EN
                    lost_d = 1'b1;
`else
                    epc_d     = pc_w;
                    code_d    = enc_code;
                    tgt_d     = HANDLER_ADDR;
                    tgt_exc_d = 1'b1;
                    state_d   = ST_FLUSH;
`endif
                end else if (ret_evt) begin
                    tgt_d     = epc_q;
                    tgt_exc_d = 1'b0;
                    state_d   = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and architectural registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            epc_q     <= '0;
            tgt_q     <= '0;
            code_q    <= 5'd0;
            lost_q    <= 1'b0;
            tgt_exc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            tgt_q     <= tgt_d;
            code_q    <= code_d;
            lost_q    <= lost_d;
            tgt_exc_q <= tgt_exc_d;
        end
    end

    // Redirect/flush only while in FLUSH; status outputs from registers
    always_comb begin
        redir_en           = 1'b0;
        redir_pc           = '0;
        flush_f            = 1'b0;
        flush_d            = 1'b0;
        flush_e            = 1'b0;
        flush_m            = 1'b0;
        cause              = '0;
        cause[6:2]         = code_q;
        cause[WIDTH_32-1]  = lost_q;
        epc                = epc_q;
        in_handler         = (state_q == ST_HANDLER);
        state_dbg          = state_q;
        if (state_q == ST_FLUSH) begin
            redir_en = 1'b1;
            redir_pc = tgt_q;
            flush_f  = 1'b1;
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            flush_m  = 1'b1;
        end
    end

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// Bench for exception_redirect_ctrl: each scenario task queues stimulus and
// the expected post-edge observation, then replays and checks them.
module tb_exception_redirect_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_HAND = 2'd2;
    localparam logic [31:0] VEC = 32'h0000_0180;

`ifdef EXC_STATUS_EN
    localparam logic STATUS_EN = 1'b1;
`else
    localparam logic STATUS_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        v;
        logic        ri;
        logic        ov;
        logic        sys;
        logic        eret;
        logic [31:0] pc;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic        valid_w;
    logic [31:0] pc_w;
    logic        exc_ri_w, exc_ov_w, exc_sys_w, eret_w;
    logic [31:0] redir_pc, epc, cause;
    logic        redir_en, flush_f, flush_d, flush_e, flush_m, in_handler;
    logic [1:0]  state_dbg;
    logic [103:0] obs;

    logic [103:0] exp_q[$];
    stim_t        stim_q[$];
    int           checks;
    int           failures;

    exception_redirect_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_w    (valid_w),
        .pc_w       (pc_w),
        .exc_ri_w   (exc_ri_w),
        .exc_ov_w   (exc_ov_w),
        .exc_sys_w  (exc_sys_w),
        .eret_w     (eret_w),
        .redir_pc   (redir_pc),
        .redir_en   (redir_en),
        .flush_f    (flush_f),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .flush_m    (flush_m),
        .epc        (epc),
        .cause      (cause),
        .in_handler (in_handler),
        .state_dbg  (state_dbg)
    );

    assign obs = {redir_en, redir_pc, flush_f, flush_d, flush_e, flush_m,
                  epc, cause, in_handler, state_dbg};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation vector
    function automatic logic [103:0] ev(logic en, logic [31:0] rpc, logic fl,
                                        logic [31:0] e, logic [4:0] code,
                                        logic lost, logic ih, logic [1:0] st);
        logic [31:0] c;
        c = '0;
        c[6:2] = code;
        c[31] = lost;
        return {en, rpc, {4{fl}}, e, c, ih, st};
    endfunction

    function automatic logic [103:0] e_flush(logic [31:0] tgt, logic [31:0] e,
                                             logic [4:0] code, logic lost);
        return ev(1'b1, tgt, 1'b1, e, code, lost, 1'b0, S_FLUSH);
    endfunction

    function automatic logic [103:0] e_hand(logic [31:0] e, logic [4:0] code, logic lost);
        return ev(1'b0, 32'h0, 1'b0, e, code, lost, 1'b1, S_HAND);
    endfunction

    function automatic logic [103:0] e_idle(logic [31:0] e, logic [4:0] code, logic lost);
        return ev(1'b0, 32'h0, 1'b0, e, code, lost, 1'b0, S_IDLE);
    endfunction

    function automatic stim_t st(logic r, logic v, logic ri, logic ov, logic sys,
                                 logic eret, logic [31:0] pc);
        stim_t s;
        s = '{rst: r, v: v, ri: ri, ov: ov, sys: sys, eret: eret, pc: pc};
        return s;
    endfunction

    // Driver: queue one cycle of stimulus and its expected result
    task automatic add(input stim_t s, input logic [103:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        rst_n     = s.rst;
        valid_w   = s.v;
        exc_ri_w  = s.ri;
        exc_ov_w  = s.ov;
        exc_sys_w = s.sys;
        eret_w    = s.eret;
        pc_w      = s.pc;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [103:0] e;
        int n;
        add(st(0, 1, 1, 0, 0, 0, 32'h55), e_idle(0, 0, 0));
        add(st(0, 1, 0, 0, 1, 1, 32'h66), e_idle(0, 0, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(0, 0, 0));
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_exception_return();
        stim_t s;
        logic [103:0] e;
        int n;
        add(st(1, 1, 0, 1, 0, 0, 32'h40), e_flush(VEC, 32'h40, 12, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h40, 12, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h40, 12, 0));
        add(st(1, 1, 0, 0, 0, 1, 32'h77), e_flush(32'h40, 32'h40, 12, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(32'h40, 12, 0));
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL exc_return step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_ignored_events();
        stim_t s;
        logic [103:0] e;
        int n;
        add(st(1, 1, 0, 0, 0, 1, 32'h99), e_idle(32'h40, 12, 0));
        add(st(1, 0, 1, 1, 1, 1, 32'h88), e_idle(32'h40, 12, 0));
        add(st(1, 1, 0, 0, 1, 0, 32'h60), e_flush(VEC, 32'h60, 8, 0));
        add(st(1, 1, 1, 0, 0, 1, 32'h99), e_hand(32'h60, 8, 0));
        add(st(1, 1, 0, 0, 0, 1, 32'h5), e_flush(32'h60, 32'h60, 8, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(32'h60, 8, 0));
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL ignored step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_priority();
        stim_t s;
        logic [103:0] e;
        int n;
        add(st(1, 1, 1, 1, 1, 0, 32'h10), e_flush(VEC, 32'h10, 10, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h10, 10, 0));
        add(st(1, 1, 0, 0, 0, 1, 32'h0), e_flush(32'h10, 32'h10, 10, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(32'h10, 10, 0));
        add(st(1, 1, 0, 1, 1, 1, 32'h14), e_flush(VEC, 32'h14, 12, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h14, 12, 0));
        add(st(1, 1, 0, 0, 0, 1, 32'h0), e_flush(32'h14, 32'h14, 12, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(32'h14, 12, 0));
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL priority step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_nested();
        stim_t s;
        logic [103:0] e;
        int n;
        add(st(1, 1, 0, 1, 0, 0, 32'h40), e_flush(VEC, 32'h40, 12, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h40, 12, 0));
        if (STATUS_EN) begin
            add(st(1, 1, 0, 0, 1, 0, 32'h200), e_hand(32'h40, 12, 1));
            add(st(1, 1, 0, 0, 0, 1, 32'h0), e_flush(32'h40, 32'h40, 12, 1));
            add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(32'h40, 12, 1));
        end else begin
            add(st(1, 1, 0, 0, 1, 0, 32'h200), e_flush(VEC, 32'h200, 8, 0));
            add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h200, 8, 0));
            add(st(1, 1, 0, 0, 0, 1, 32'h0), e_flush(32'h200, 32'h200, 8, 0));
            add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(32'h200, 8, 0));
        end
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL nested step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_priority();
        stim_t s;
        logic [103:0] e;
        int n;
        add(st(1, 1, 1, 0, 0, 0, 32'h30), e_flush(VEC, 32'h30, 10, STATUS_EN));
        add(st(0, 0, 0, 0, 0, 0, 32'h0), e_idle(0, 0, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(0, 0, 0));
        add(st(1, 1, 1, 0, 0, 0, 32'h34), e_flush(VEC, 32'h34, 10, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(32'h34, 10, 0));
        add(st(0, 1, 0, 0, 0, 1, 32'h0), e_idle(0, 0, 0));
        add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(0, 0, 0));
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_prio step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        logic [103:0] e;
        logic [31:0] p1, p2, p3;
        int n;
        for (int k = 0; k < 4; k++) begin
            p1 = 32'($urandom_range(1, 4000)) << 2;
            p2 = 32'($urandom_range(1, 4000)) << 2;
            p3 = 32'($urandom_range(1, 4000)) << 2;
            add(st(1, 1, 0, 1, 0, 0, p1), e_flush(VEC, p1, 12, 0));
            add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(p1, 12, 0));
            add(st(1, 1, 0, 0, 0, 1, p2), e_flush(p1, p1, 12, 0));
            add(st(1, 1, 1, 0, 0, 0, p2), e_idle(p1, 12, 0));
            add(st(1, 1, 0, 0, 1, 0, p3), e_flush(VEC, p3, 8, 0));
            add(st(1, 0, 0, 0, 0, 0, 32'h0), e_hand(p3, 8, 0));
            add(st(1, 1, 0, 0, 0, 1, p1), e_flush(p3, p3, 8, 0));
            add(st(1, 0, 0, 0, 0, 0, 32'h0), e_idle(p3, 8, 0));
        end
        n = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back step=%0d got=%h exp=%h", n, obs, e);
            end
            n++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        apply(st(0, 0, 0, 0, 0, 0, 32'h0));
        @(posedge clk); #1;
        test_reset();
        test_exception_return();
        test_ignored_events();
        test_priority();
        test_nested();
        test_reset_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
